// File: rtl/link_vc_scheduler.sv
// Two-VC link scheduler: per-VC credit tracking, round-robin grant between
// eligible VCs, and a registered single-flit link output stage.
`ifndef TAM_FLIT
`define TAM_FLIT 32
`endif

module link_vc_credit #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          grant_i,
    input  logic          credit_i,
    output logic [CW-1:0] cnt_o,
    output logic          ovf_o
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        if (grant_i && !credit_i) begin
            cnt_d = cnt_q - 1'b1;
        end else if (credit_i && !grant_i) begin
            // A return beyond DEPTH is a protocol error; saturate and flag it.
            if (cnt_q == FULL) ovf_o = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= FULL;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module link_vc_scheduler #(
    parameter int FLIT_W = `TAM_FLIT,
    parameter int DEPTH  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          data_av,
    input  logic [2*FLIT_W-1:0] data_in,
    input  logic [1:0]          credit_i,
    output logic [1:0]          data_ack,
    output logic                tx,
    output logic [1:0]          lane_tx,
    output logic [FLIT_W-1:0]   data_out,
    output logic                credit_err
);
    localparam int NUM_LANES = 2;
    localparam int CW        = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              vld;
        logic [1:0]        lane;
        logic [FLIT_W-1:0] flit;
    } link_t;

    logic [NUM_LANES-1:0][CW-1:0] cnt;
    logic [NUM_LANES-1:0]         ovf, elig, grant;
    logic                         last_q, last_d;
    logic                         err_q;
    link_t                        link_q, link_d;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        link_vc_credit #(.DEPTH(DEPTH), .CW(CW)) u_credit (
            .clock    (clock),
            .reset    (reset),
            .grant_i  (grant[n]),
            .credit_i (credit_i[n]),
            .cnt_o    (cnt[n]),
            .ovf_o    (ovf[n])
        );
        assign elig[n] = data_av[n] && (cnt[n] != '0);
    end

    // last_q names the VC served most recently; on contention the other wins.
    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (grant[0])      last_d = 1'b0;
        else if (grant[1]) last_d = 1'b1;
    end

    always_comb begin
        link_d      = link_q;
        link_d.vld  = |grant;
        link_d.lane = grant;
        if (grant[0])      link_d.flit = data_in[0 +: FLIT_W];
        else if (grant[1]) link_d.flit = data_in[FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
            err_q  <= 1'b0;
            link_q <= '0;
        end else begin
            last_q <= last_d;
            err_q  <= err_q | (|ovf);
            link_q <= link_d;
        end
    end

    // Counters sit at DEPTH during reset, so the ack must be masked explicitly.
    assign data_ack   = reset ? 2'b00 : grant;
    assign tx         = link_q.vld;
    assign lane_tx    = link_q.lane;
    assign data_out   = link_q.flit;
    assign credit_err = err_q;
endmodule

// File: tb/tb_link_vc_scheduler.sv
// Scoreboard bench for link_vc_scheduler: directed per-cycle vectors push
// expected ack/link values; monitors pop and compare as the DUT presents them.
`timescale 1ns/100ps

module tb_link_vc_scheduler;
    localparam int FW = 32;
    localparam int D  = 4;

    typedef struct {
        logic          tx;
        logic [1:0]    lane;
        logic [FW-1:0] data;
        logic          err;
    } out_exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      data_av = 2'b00;
    logic [2*FW-1:0] data_in = '0;
    logic [1:0]      credit_i = 2'b00;
    logic [1:0]      data_ack;
    logic            tx;
    logic [1:0]      lane_tx;
    logic [FW-1:0]   data_out;
    logic            credit_err;

    out_exp_t      out_q[$];
    logic [1:0]    ack_q[$];
    logic [FW-1:0] held = '0;
    int            vn = 0;
    int            pass_n = 0;
    int            tot_n = 0;

    link_vc_scheduler #(.FLIT_W(FW), .DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_av    (data_av),
        .data_in    (data_in),
        .credit_i   (credit_i),
        .data_ack   (data_ack),
        .tx         (tx),
        .lane_tx    (lane_tx),
        .data_out   (data_out),
        .credit_err (credit_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Link monitor: registered outputs, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (out_q.size() > 0) begin
                out_exp_t e;
                e = out_q.pop_front();
                chk("tx", 64'(tx), 64'(e.tx));
                chk("lane_tx", 64'(lane_tx), 64'(e.lane));
                chk("data_out", 64'(data_out), 64'(e.data));
                chk("credit_err", 64'(credit_err), 64'(e.err));
            end
        end
    end

    // Ack monitor: combinational ack, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (ack_q.size() > 0) begin
                logic [1:0] a;
                a = ack_q.pop_front();
                chk("data_ack", 64'(data_ack), 64'(a));
            end
        end
    end

    // One clock cycle of stimulus with the hand-computed ack and sticky error.
    task automatic cyc(input logic [1:0] av, input logic [1:0] cr,
                       input logic [1:0] e_ack, input logic e_err);
        out_exp_t e;
        logic [FW-1:0] a0, a1;
        @(posedge clock);
        #2;
        vn++;
        a0 = 32'hA000_0000 + FW'(vn);
        a1 = 32'hB000_0000 + FW'(vn);
        data_av  = av;
        credit_i = cr;
        data_in  = {a1, a0};
        ack_q.push_back(e_ack);
        if (e_ack == 2'b01)      held = a0;
        else if (e_ack == 2'b10) held = a1;
        e.tx   = |e_ack;
        e.lane = e_ack;
        e.data = held;
        e.err  = e_err;
        out_q.push_back(e);
    endtask

    // Asserted between edges so the asynchronous clear is observable at once.
    task automatic do_reset();
        @(posedge clock);
        #3;
        reset    = 1'b1;
        data_av  = 2'b11;
        credit_i = 2'b00;
        #1;
        chk("rst_tx", 64'(tx), 64'd0);
        chk("rst_lane", 64'(lane_tx), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_ack", 64'(data_ack), 64'd0);
        out_q.delete();
        ack_q.delete();
        held = '0;
        repeat (2) @(posedge clock);
        #3;
        chk("rst_ack_hold", 64'(data_ack), 64'd0);
        chk("rst_tx_hold", 64'(tx), 64'd0);
        reset   = 1'b0;
        data_av = 2'b00;
    endtask

    initial begin
        do_reset();

        // Contention from reset: VC0 first, then strict alternation.
        for (int i = 0; i < 6; i++) cyc(2'b11, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 1'b0);

        // DEPTH flits on VC0, stall, then a single credit releases one more.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(2'b01, 2'b00, 2'b01, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 2'b01, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 2'b01, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 1'b0);

        // VC0 is out of credit: VC1 alone is served; a credit coinciding with
        // a grant at cnt=2 leaves it at 2, so five flits pass instead of four.
        cyc(2'b11, 2'b00, 2'b10, 1'b0);
        cyc(2'b11, 2'b00, 2'b10, 1'b0);
        cyc(2'b11, 2'b10, 2'b10, 1'b0);
        cyc(2'b11, 2'b00, 2'b10, 1'b0);
        cyc(2'b11, 2'b00, 2'b10, 1'b0);
        cyc(2'b11, 2'b00, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 1'b0);

        // Overflowing credit right after reset: sticky error, count stays DEPTH.
        do_reset();
        cyc(2'b00, 2'b01, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) cyc(2'b01, 2'b00, 2'b01, 1'b1);
        cyc(2'b01, 2'b00, 2'b00, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 1'b1);

        // Flit in flight on VC1 when reset hits between edges.
        cyc(2'b10, 2'b00, 2'b10, 1'b1);
        do_reset();

        cyc(2'b00, 2'b00, 2'b00, 1'b0);
        @(posedge clock);
        #3;
        chk("sb_out_drained", 64'(out_q.size()), 64'd0);
        chk("sb_ack_drained", 64'(ack_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
